flag_unit: RTL and testbench

Parametrised flag/status unit for the CPU datapath: compares the two operand buses (signed or unsigned) into separate EQ/GT/LT flags, holds the interrupt-mask bit, and keeps a small LIFO of saved flag words for interrupt entry/return. It sits beside the ALU on bus1/bus2 and drives the condition-code bus read by the control unit's branch logic. It is the successor to the single-register comparator and replaces it on the same buses.

---
 rtl/flag_pkg.sv | 24 ++
 rtl/flag_unit_if.sv | 43 ++++
 rtl/flag_stack.sv | 67 ++++++
 rtl/flag_unit.sv | 101 ++++++++++
 tb/tb_flag_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flag_pkg                                                     |
// | Description : Shared constants for the flag/status unit: bit positions     |
// |               inside the flag word, flag field width and reset word.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package flag_pkg;

    // Width of the live flag field; bits above this always read 0 on bus1.
    localparam int c_FLAG_W = 5;

    // Bit positions inside the flag word.
    localparam int c_EQ    = 0;
    localparam int c_GT    = 1;
    localparam int c_IMASK = 2;
    localparam int c_LT    = 3;
    localparam int c_SERR  = 4;

    // Interrupts come out of reset masked.
    localparam logic [c_FLAG_W-1:0] c_RESET_FLAGS = 5'b00100;

endpackage
`default_nettype wire

// File: rtl/flag_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flag_unit_if                                                 |
// | Description : Command, operand and status bundle of the flag unit.         |
// |               master: control side (drives commands and bus2, reads status)|
// |               slave : flag unit (reads commands and bus2, drives status)   |
// |               Ports : load, push, compare, signed_cmp, mask_int,           |
// |                       unmask_int, save, restore, bus2 / f_bus,             |
// |                       stack_full, stack_empty                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface flag_unit_if #(
    parameter int WIDTH = 16
);
    import flag_pkg::*;

    logic                load;
    logic                push;
    logic                compare;
    logic                signed_cmp;
    logic                mask_int;
    logic                unmask_int;
    logic                save;
    logic                restore;
    logic [WIDTH-1:0]    bus2;
    logic [c_FLAG_W-1:0] f_bus;
    logic                stack_full;
    logic                stack_empty;

    modport master (
        output load, push, compare, signed_cmp, mask_int, unmask_int,
               save, restore, bus2,
        input  f_bus, stack_full, stack_empty
    );

    modport slave (
        input  load, push, compare, signed_cmp, mask_int, unmask_int,
               save, restore, bus2,
        output f_bus, stack_full, stack_empty
    );

endinterface
`default_nettype wire

// File: rtl/flag_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flag_stack                                                   |
// | Description : Small LIFO for saved flag words.                             |
// |               Ports : clk, rst, i_push, i_pop, i_data -> o_top, o_full,    |
// |                       o_empty. Push is ignored when full, pop when empty;  |
// |                       push takes precedence if both are asserted.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flag_stack #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_top,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH + 1);

    // r_ptr counts held entries: next write slot, and top entry is r_ptr-1.
    logic [c_PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_ptr == c_PTR_W'(DEPTH));
    assign o_empty   = (r_ptr == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !i_push && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_push_ok) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (w_pop_ok) begin
            r_ptr <= r_ptr - 1'b1;
        end
    end

    // Per-entry write decode keeps the pointer width independent of the
    // array index width for any DEPTH.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst && w_push_ok && (r_ptr == c_PTR_W'(i))) begin
                r_mem[i] <= i_data;
            end
        end
    end

    always_comb begin
        o_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ptr == c_PTR_W'(i + 1)) begin
                o_top = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flag_unit                                                    |
// | Description : Flag/status unit beside the ALU. Compares bus1 with bus2     |
// |               (signed or unsigned) into EQ/GT/LT, holds IMASK, tracks a    |
// |               sticky stack-error bit and saves/restores the flag word on   |
// |               a LIFO for interrupt entry/return.                           |
// |               Ports : clk, rst, bus1 (inout, driven under push),           |
// |                       bus_if (flag_unit_if.slave: commands, bus2, f_bus,   |
// |                       stack_full, stack_empty)                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    inout  wire [WIDTH-1:0] bus1,
    flag_unit_if.slave      bus_if
);

    logic [c_FLAG_W-1:0] r_flags;
    logic [c_FLAG_W-1:0] w_next;
    logic [c_FLAG_W-1:0] w_top;
    logic                w_full;
    logic                w_empty;
    logic                w_save_ok;
    logic                w_rest_ok;
    logic                w_err;
    logic                w_eq;
    logic                w_gt;

    assign w_eq = (bus1 == bus_if.bus2);
    assign w_gt = bus_if.signed_cmp ? ($signed(bus1) > $signed(bus_if.bus2))
                                    : (bus1 > bus_if.bus2);

    // A simultaneous save and restore is an error and touches neither side
    // of the stack.
    assign w_save_ok = bus_if.save && !bus_if.restore && !w_full;
    assign w_rest_ok = bus_if.restore && !bus_if.save && !w_empty;
    assign w_err     = (bus_if.save && bus_if.restore)
                     || (bus_if.save && w_full)
                     || (bus_if.restore && w_empty);

    always_comb begin
        w_next = r_flags;
        if (w_rest_ok) begin
            w_next = w_top;
        end else if (bus_if.load) begin
            // Under push, bus1 carries r_flags, so this reloads the same word.
            w_next = bus1[c_FLAG_W-1:0];
        end else if (bus_if.compare) begin
            w_next[c_EQ] = w_eq;
            w_next[c_GT] = w_gt;
            w_next[c_LT] = !w_eq && !w_gt;
        end

        if (bus_if.mask_int || bus_if.save) begin
            w_next[c_IMASK] = 1'b1;
        end else if (bus_if.unmask_int) begin
            w_next[c_IMASK] = 1'b0;
        end

        if (w_err) begin
            w_next[c_SERR] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= c_RESET_FLAGS;
        end else begin
            r_flags <= w_next;
        end
    end

    // The stack saves the pre-update flag word.
    flag_stack #(
        .WIDTH (c_FLAG_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_save_ok),
        .i_pop   (w_rest_ok),
        .i_data  (r_flags),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus1               = bus_if.push ? WIDTH'(r_flags) : {WIDTH{1'bz}};
    assign bus_if.f_bus       = r_flags;
    assign bus_if.stack_full  = w_full;
    assign bus_if.stack_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flag_unit                                                 |
// | Description : Self-checking bench for flag_unit: directed vector table,    |
// |               hand sequences for bus1 drive/release and save/restore, and  |
// |               randomized commands against a behavioural model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flag_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic        rst;
        logic        load;
        logic        push;
        logic        cmp;
        logic        scmp;
        logic        mask;
        logic        unmask;
        logic        save;
        logic        restore;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [4:0]  ef;
        logic        efull;
        logic        eempty;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_drv_en;
    logic [15:0] r_drv;
    wire  [15:0] bus1;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: flag word plus a queue of saved words.
    logic [4:0] m_flags;
    logic [4:0] m_stack [$];

    vec_t vecs [26];

    flag_unit_if #(.WIDTH(WIDTH)) u_if ();

    flag_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus1   (bus1),
        .bus_if (u_if.slave)
    );

    assign bus1 = r_drv_en ? r_drv : 16'bz;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst              = v.rst;
        u_if.load        = v.load;
        u_if.push        = v.push;
        u_if.compare     = v.cmp;
        u_if.signed_cmp  = v.scmp;
        u_if.mask_int    = v.mask;
        u_if.unmask_int  = v.unmask;
        u_if.save        = v.save;
        u_if.restore     = v.restore;
        u_if.bus2        = v.b2;
        r_drv            = v.b1;
        r_drv_en         = !v.push;
    endtask

    task automatic step(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              16'h0, 16'h0, 5'b0, 1'b0, 1'b0};
        return v;
    endfunction

    // Next model state from the rules: priority restore > load > compare,
    // then IMASK override, then the sticky error bit.
    task automatic model_step(input vec_t v);
        logic [15:0] b1;
        logic [4:0]  nf;
        longint      a;
        longint      b;
        bit          err;
        if (v.rst) begin
            m_flags = 5'b00100;
            m_stack.delete();
            return;
        end
        b1  = v.push ? {11'b0, m_flags} : v.b1;
        err = (v.save && v.restore) || (v.save && m_stack.size() == DEPTH)
              || (v.restore && m_stack.size() == 0);
        nf  = m_flags;
        if (v.restore && !v.save && m_stack.size() > 0) begin
            nf = m_stack[$];
        end else if (v.load) begin
            nf = b1[4:0];
        end else if (v.cmp) begin
            a = longint'(b1);
            b = longint'(v.b2);
            if (v.scmp) begin
                if (a >= 32768) a = a - 65536;
                if (b >= 32768) b = b - 65536;
            end
            nf[0] = (a == b);
            nf[1] = (a > b);
            nf[3] = (a < b);
        end
        if (v.mask || v.save) nf[2] = 1'b1;
        else if (v.unmask)    nf[2] = 1'b0;
        if (err) nf[4] = 1'b1;
        if (v.save && !v.restore && m_stack.size() < DEPTH) begin
            m_stack.push_back(m_flags);
        end else if (v.restore && !v.save && m_stack.size() > 0) begin
            void'(m_stack.pop_back());
        end
        m_flags = nf;
    endtask

    initial begin
        vec_t v;

        //          rst  ld   psh  cmp  scm  msk  umk  sav  rsr  b1        b2        ef        full  empty
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,5'b00100,1'b0,1'b1};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,5'b00100,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFF,16'h0001,5'b00110,1'b0,1'b1};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'hFFFF,16'h0001,5'b01100,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFE3,16'h0000,5'b00011,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0001,16'h0000,5'b00001,1'b0,1'b1};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00101,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b10101,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b00001,1'b0,1'b1};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b10001,1'b0,1'b1};
        vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0004,16'h0000,5'b00100,1'b0,1'b1};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0000,5'b10100,1'b0,1'b1};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0005,16'h0005,5'b10101,1'b0,1'b1};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,5'b10001,1'b0,1'b1};
        vecs[20] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0001,16'h0000,5'b00001,1'b0,1'b1};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00101,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,5'b00100,1'b0,1'b1};
        vecs[23] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,5'b10100,1'b0,1'b1};
        vecs[24] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h8000,16'h7FFF,5'b11100,1'b0,1'b1};
        vecs[25] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h8000,16'h7FFF,5'b10110,1'b0,1'b1};

        drive(idle());

        // Directed table.
        for (int i = 0; i < 26; i++) begin
            step(vecs[i]);
            check($sformatf("tbl%0d f_bus", i), {11'b0, u_if.f_bus}, {11'b0, vecs[i].ef});
            check($sformatf("tbl%0d full", i), {15'b0, u_if.stack_full}, {15'b0, vecs[i].efull});
            check($sformatf("tbl%0d empty", i), {15'b0, u_if.stack_empty}, {15'b0, vecs[i].eempty});
        end

        // bus1 released while idle, then driven with the flag word under push.
        v = idle(); v.rst = 1'b1;
        step(v);
        v = idle(); v.b1 = 16'h5A5A;
        drive(v);
        #1;
        check("bus1 released", bus1, 16'h5A5A);
        v = idle(); v.load = 1'b1; v.b1 = 16'hFFE3;
        step(v);
        v = idle(); v.push = 1'b1;
        drive(v);
        #1;
        check("push drives flags", bus1, 16'h0003);
        v = idle(); v.push = 1'b1; v.load = 1'b1;
        step(v);
        check("load+push no-op", {11'b0, u_if.f_bus}, 16'h0003);

        // Save then restore back to back returns the original word.
        v = idle(); v.load = 1'b1; v.b1 = 16'h0008;
        step(v);
        v = idle(); v.save = 1'b1;
        step(v);
        check("save sets imask", {11'b0, u_if.f_bus}, 16'h000C);
        v = idle(); v.restore = 1'b1;
        step(v);
        check("restore original", {11'b0, u_if.f_bus}, 16'h0008);
        check("restore empty", {15'b0, u_if.stack_empty}, 16'h0001);

        // Randomized commands against the model.
        v = idle(); v.rst = 1'b1;
        model_step(v);
        step(v);
        for (int i = 0; i < 600; i++) begin
            v = idle();
            v.rst     = ($urandom_range(0, 63) == 0);
            v.load    = ($urandom_range(0, 5) == 0);
            v.push    = ($urandom_range(0, 5) == 0);
            v.cmp     = ($urandom_range(0, 2) == 0);
            v.scmp    = $urandom_range(0, 1);
            v.mask    = ($urandom_range(0, 7) == 0);
            v.unmask  = ($urandom_range(0, 5) == 0);
            v.save    = ($urandom_range(0, 3) == 0);
            v.restore = ($urandom_range(0, 3) == 0);
            v.b1      = 16'($urandom);
            v.b2      = ($urandom_range(0, 3) == 0) ? v.b1 : 16'($urandom);
            drive(v);
            #1;
            if (v.push) begin
                check($sformatf("rnd%0d bus1", i), bus1, {11'b0, m_flags});
            end
            model_step(v);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d f_bus", i), {11'b0, u_if.f_bus}, {11'b0, m_flags});
            check($sformatf("rnd%0d full", i), {15'b0, u_if.stack_full},
                  {15'b0, (m_stack.size() == DEPTH)});
            check($sformatf("rnd%0d empty", i), {15'b0, u_if.stack_empty},
                  {15'b0, (m_stack.size() == 0)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
